axis_gearbox: RTL and testbench

AXI4-Stream width converter for arbitrary byte-lane ratios; input and output lane counts need not be integer multiples of each other (e.g. 3→4, 5→2). Byte-granular accumulator with packet-boundary flush, in the same stream datapath family as the integer-ratio adapter. Sits between stream stages whose widths are fixed by unrelated IP, e.g. 24-bit pixel streams feeding 32-bit DMA.

---
 rtl/axis_gearbox_pkg.sv | 18 +
 rtl/axis_gearbox_if.sv | 20 ++
 rtl/axis_gearbox_buf.sv | 50 +++++
 rtl/axis_gearbox.sv | 150 +++++++++++++++
 tb/tb_axis_gearbox.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_gearbox_pkg.sv
// Shared types and lane-count helpers for the arbitrary-ratio stream gearbox.
package axis_gearbox_pkg;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } gb_state_e;

  // Lanes seen by the datapath: a stream without tkeep moves one whole word per beat.
  function automatic int lane_count(input bit keep_en, input int keep_w);
    return keep_en ? keep_w : 1;
  endfunction

  function automatic int buf_lanes(input int s_lanes, input int m_lanes);
    return 2 * (s_lanes + m_lanes);
  endfunction

endpackage

// File: rtl/axis_gearbox_if.sv
// AXI4-Stream bundle; master drives payload and valid, slave drives ready.
interface axis_gearbox_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_gearbox_buf.sv
// Byte-lane buffer: lane 0 is oldest; shifts out n lanes and appends at (count - n) in one cycle.
// Lanes at and above count are always zero, so appends merge with a plain OR.
module axis_gearbox_buf #(
  parameter int LANES     = 14,
  parameter int LW        = 8,
  parameter int IN_LANES  = 3,
  parameter int OUT_LANES = 4,
  parameter int CW        = $clog2(LANES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      app_vld_i,
  input  logic [IN_LANES*LW-1:0]    app_dat_i,
  input  logic [CW-1:0]             app_n_i,
  input  logic [CW-1:0]             shift_n_i,
  output logic [OUT_LANES*LW-1:0]   head_dat_o,
  output logic [CW-1:0]             count_o,
  output logic [CW-1:0]             count_nxt_o
);
  localparam int BW = LANES * LW;

  logic [BW-1:0] buf_q, buf_d, app_ext;
  logic [CW-1:0] count_q, count_d, base;

  always_comb begin
    app_ext = '0;
    for (int i = 0; i < IN_LANES; i++) begin
      if (app_vld_i && (i < int'(app_n_i))) begin
        app_ext[i*LW +: LW] = app_dat_i[i*LW +: LW];
      end
    end
    base    = count_q - shift_n_i;
    buf_d   = (buf_q >> (int'(shift_n_i) * LW)) | (app_ext << (int'(base) * LW));
    count_d = base + (app_vld_i ? app_n_i : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  assign head_dat_o  = buf_q[OUT_LANES*LW-1:0];
  assign count_o     = count_q;
  assign count_nxt_o = count_d;
endmodule

// File: rtl/axis_gearbox.sv
// AXI4-Stream width converter for arbitrary lane ratios; output beat registered one cycle after
// M bytes are buffered or tlast is accepted. Input stalls while flushing a packet or near full.
module axis_gearbox
  import axis_gearbox_pkg::*;
#(
  parameter int S_DATA_WIDTH  = 24,
  parameter bit S_KEEP_ENABLE = (S_DATA_WIDTH > 8),
  parameter int S_KEEP_WIDTH  = ((S_DATA_WIDTH + 7) / 8),
  parameter int M_DATA_WIDTH  = 32,
  parameter bit M_KEEP_ENABLE = (M_DATA_WIDTH > 8),
  parameter int M_KEEP_WIDTH  = ((M_DATA_WIDTH + 7) / 8),
  parameter bit ID_ENABLE     = 1'b0,
  parameter int ID_WIDTH      = 8,
  parameter bit DEST_ENABLE   = 1'b0,
  parameter int DEST_WIDTH    = 8,
  parameter bit USER_ENABLE   = 1'b1,
  parameter int USER_WIDTH    = 1
) (
  input logic            clk,
  input logic            rst,
  axis_gearbox_if.slave  s_axis,
  axis_gearbox_if.master m_axis
);
  localparam int S        = lane_count(S_KEEP_ENABLE, S_KEEP_WIDTH);
  localparam int M        = lane_count(M_KEEP_ENABLE, M_KEEP_WIDTH);
  localparam int LW       = S_DATA_WIDTH / S;
  localparam int BUF      = buf_lanes(S, M);
  localparam int CW       = $clog2(BUF + 1);
  localparam logic [CW-1:0] M_C     = CW'(M);
  localparam logic [CW-1:0] RDY_LIM = CW'(BUF - S);

  if ((S * LW != S_DATA_WIDTH) || (M * LW != M_DATA_WIDTH)) begin : g_bad_cfg
    $error("axis_gearbox: input and output byte sizes differ");
  end

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
  } sb_t;

  gb_state_e               state_q;
  logic                    s_rdy_q, first_q;
  sb_t                     sb_q, sb_in, m_sb_q;
  logic                    m_vld_q, m_last_q;
  logic [M_DATA_WIDTH-1:0] m_dat_q, head;
  logic [M_KEEP_WIDTH-1:0] m_keep_q, keep_mask;

  logic          s_fire, out_free, load, load_last;
  logic [CW-1:0] in_n, take_n, shift_n, count, count_nxt;

  always_comb begin
    s_fire   = s_axis.tvalid && s_rdy_q;
    in_n     = S_KEEP_ENABLE ? CW'($countones(s_axis.tkeep)) : CW'(1);
    sb_in    = '{id: s_axis.tid, dest: s_axis.tdest, user: s_axis.tuser};
    out_free = !m_vld_q || m_axis.tready;
    take_n   = (count < M_C) ? count : M_C;
    load     = out_free && ((state_q == FLUSH) || (count >= M_C));
    // A zero-byte tlast arriving as exactly M bytes leave lets that beat carry tlast itself.
    if (state_q == FLUSH) begin
      load_last = load && (count <= M_C);
    end else begin
      load_last = load && s_fire && s_axis.tlast && (count == M_C) && (in_n == '0);
    end
    shift_n   = load ? take_n : '0;
    keep_mask = '0;
    for (int i = 0; i < M_KEEP_WIDTH; i++) begin
      keep_mask[i] = (i < int'(take_n));
    end
  end

  axis_gearbox_buf #(
    .LANES     (BUF),
    .LW        (LW),
    .IN_LANES  (S),
    .OUT_LANES (M),
    .CW        (CW)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .app_vld_i   (s_fire),
    .app_dat_i   (s_axis.tdata),
    .app_n_i     (in_n),
    .shift_n_i   (shift_n),
    .head_dat_o  (head),
    .count_o     (count),
    .count_nxt_o (count_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      s_rdy_q  <= 1'b1;
      first_q  <= 1'b1;
      sb_q     <= '0;
      m_vld_q  <= 1'b0;
      m_dat_q  <= '0;
      m_keep_q <= '0;
      m_last_q <= 1'b0;
      m_sb_q   <= '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (s_fire && s_axis.tlast && !load_last) begin
            state_q <= FLUSH;
            s_rdy_q <= 1'b0;
          end else begin
            s_rdy_q <= (count_nxt <= RDY_LIM);
          end
        end
        FLUSH: begin
          if (load_last) begin
            state_q <= FILL;
            s_rdy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= FILL;
          s_rdy_q <= 1'b1;
        end
      endcase

      if (s_fire && first_q) begin
        sb_q <= sb_in;
      end
      if (s_fire) begin
        first_q <= s_axis.tlast;
      end

      if (load) begin
        m_vld_q  <= 1'b1;
        m_dat_q  <= head;
        m_keep_q <= keep_mask;
        m_last_q <= load_last;
        m_sb_q   <= sb_q;
      end else if (m_axis.tready) begin
        m_vld_q <= 1'b0;
      end
    end
  end

  assign s_axis.tready = s_rdy_q;
  assign m_axis.tvalid = m_vld_q;
  assign m_axis.tdata  = m_dat_q;
  assign m_axis.tkeep  = M_KEEP_ENABLE ? m_keep_q : '1;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tid    = ID_ENABLE ? m_sb_q.id : '0;
  assign m_axis.tdest  = DEST_ENABLE ? m_sb_q.dest : '0;
  assign m_axis.tuser  = USER_ENABLE ? m_sb_q.user : '0;
endmodule

// File: tb/tb_axis_gearbox.sv
// Bench for axis_gearbox: 3->4 lane instance (tid enabled) with directed packets, 5->2 lane instance with random traffic.
module tb_axis_gearbox;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_gearbox_if #(.DATA_WIDTH(24), .KEEP_WIDTH(3)) sa ();
  axis_gearbox_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) ma ();
  axis_gearbox_if #(.DATA_WIDTH(40), .KEEP_WIDTH(5)) sb ();
  axis_gearbox_if #(.DATA_WIDTH(16), .KEEP_WIDTH(2)) mb ();

  axis_gearbox #(.S_DATA_WIDTH(24), .M_DATA_WIDTH(32), .ID_ENABLE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .s_axis(sa), .m_axis(ma)
  );
  axis_gearbox #(.S_DATA_WIDTH(40), .M_DATA_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .s_axis(sb), .m_axis(mb)
  );

  typedef struct packed {
    logic [63:0] dat;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  id;
    logic        user;
  } beat_t;

  beat_t exp_a[$];
  beat_t exp_b[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    rr_a = 1'b0;
  bit    rr_b = 1'b0;
  logic [7:0] pq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: a packet's bytes leave in M-byte groups in order, the last group (possibly short)
  // carries tlast, and a byte-less packet yields one empty tlast beat; sideband from beat one.
  task automatic model_pkt(input int sel, input int m, input logic [7:0] b[$],
                           input logic [7:0] id, input logic u);
    beat_t bt;
    int n;
    n = b.size();
    if (n == 0) begin
      bt = '0; bt.last = 1'b1; bt.id = id; bt.user = u;
      if (sel == 0) exp_a.push_back(bt); else exp_b.push_back(bt);
    end
    for (int p = 0; p < n; p += m) begin
      bt = '0; bt.id = id; bt.user = u;
      for (int i = 0; i < m && p + i < n; i++) begin
        bt.dat[8*i +: 8] = b[p+i];
        bt.keep[i] = 1'b1;
      end
      bt.last = (p + m >= n);
      if (sel == 0) exp_a.push_back(bt); else exp_b.push_back(bt);
    end
  endtask

  task automatic mon_beat(input int sel, input logic [63:0] d, input logic [7:0] k,
                          input logic l, input logic [7:0] id, input logic u);
    beat_t e;
    logic [63:0] msk;
    string pfx;
    pfx = (sel == 0) ? "a" : "b";
    if ((sel == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0)) begin
      chk({pfx, "_unexpected_beat"}, 64'd1, 64'd0);
      return;
    end
    e = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
    msk = '0;
    for (int i = 0; i < 8; i++) if (e.keep[i]) msk[8*i +: 8] = 8'hFF;
    chk({pfx, "_keep"}, 64'(k), 64'(e.keep));
    chk({pfx, "_data"}, d & msk, e.dat);
    chk({pfx, "_last"}, 64'(l), 64'(e.last));
    chk({pfx, "_tid"},  64'(id), 64'(e.id));
    chk({pfx, "_tuser"}, 64'(u), 64'(e.user));
  endtask

  always @(negedge clk) begin
    if (!rst && ma.tvalid && ma.tready)
      mon_beat(0, 64'(ma.tdata), 8'(ma.tkeep), ma.tlast, ma.tid, ma.tuser);
  end

  logic [63:0] b_snap;
  logic        b_stalled;
  always @(negedge clk) begin
    if (rst) begin
      b_stalled <= 1'b0;
    end else begin
      if (b_stalled) chk("b_stall_hold", 64'({mb.tvalid, mb.tlast, mb.tkeep, mb.tdata}), b_snap);
      if (mb.tvalid && mb.tready)
        mon_beat(1, 64'(mb.tdata), 8'(mb.tkeep), mb.tlast, mb.tid, mb.tuser);
      b_stalled <= mb.tvalid && !mb.tready;
      b_snap    <= 64'({mb.tvalid, mb.tlast, mb.tkeep, mb.tdata});
    end
  end

  initial begin
    ma.tready = 1'b1;
    mb.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ma.tready = rr_a ? 1'($urandom_range(0, 1)) : 1'b1;
      mb.tready = rr_b ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_a(input logic [23:0] d, input logic [2:0] k, input logic l,
                        input logic [7:0] id, input logic u);
    int t;
    logic acc;
    sa.tdata = d; sa.tkeep = k; sa.tlast = l; sa.tid = id; sa.tdest = '0; sa.tuser = u;
    sa.tvalid = 1'b1;
    t = 0; acc = 1'b0;
    while (!acc && t < 1000) begin
      @(negedge clk); acc = sa.tready;
      @(posedge clk); #1; t++;
    end
    sa.tvalid = 1'b0;
    if (!acc) chk("a_send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_b(input logic [39:0] d, input logic [4:0] k, input logic l,
                        input logic [7:0] id, input logic u);
    int t;
    logic acc;
    sb.tdata = d; sb.tkeep = k; sb.tlast = l; sb.tid = id; sb.tdest = '0; sb.tuser = u;
    sb.tvalid = 1'b1;
    t = 0; acc = 1'b0;
    while (!acc && t < 1000) begin
      @(negedge clk); acc = sb.tready;
      @(posedge clk); #1; t++;
    end
    sb.tvalid = 1'b0;
    if (!acc) chk("b_send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_pkt_a(input logic [7:0] b[$], input logic [7:0] id, input logic u);
    int n;
    logic [23:0] d;
    logic [2:0]  k;
    n = b.size();
    model_pkt(0, 4, b, id, u);
    for (int p = 0; p < n; p += 3) begin
      d = '0; k = '0;
      for (int i = 0; i < 3 && p + i < n; i++) begin
        d[8*i +: 8] = b[p+i];
        k[i] = 1'b1;
      end
      send_a(d, k, (p + 3 >= n), id, u);
    end
  endtask

  task automatic send_pkt_b(input logic [7:0] b[$], input logic [7:0] id, input logic u);
    int n;
    logic [39:0] d;
    logic [4:0]  k;
    n = b.size();
    model_pkt(1, 2, b, 8'h00, u);
    for (int p = 0; p < n; p += 5) begin
      d = '0; k = '0;
      for (int i = 0; i < 5 && p + i < n; i++) begin
        d[8*i +: 8] = b[p+i];
        k[i] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send_b(d, k, (p + 5 >= n), id, u);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int t;
    t = 0;
    while ((exp_a.size() + exp_b.size()) != 0 && t < budget) begin
      @(posedge clk); #1; t++;
    end
    chk(tag, 64'(exp_a.size() + exp_b.size()), 64'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t bt;
    sa.tvalid = 1'b0; sa.tdata = '0; sa.tkeep = '0; sa.tlast = 1'b0;
    sa.tid = '0; sa.tdest = '0; sa.tuser = '0;
    sb.tvalid = 1'b0; sb.tdata = '0; sb.tkeep = '0; sb.tlast = 1'b0;
    sb.tid = '0; sb.tdest = '0; sb.tuser = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("a_rst_s_tready", 64'(sa.tready), 64'd1);
    chk("a_rst_m_tvalid", 64'(ma.tvalid), 64'd0);
    chk("a_rst_m_tlast",  64'(ma.tlast),  64'd0);
    chk("a_rst_m_tkeep",  64'(ma.tkeep),  64'd0);
    chk("a_rst_m_tdata",  64'(ma.tdata),  64'd0);
    chk("a_rst_m_tid",    64'(ma.tid),    64'd0);
    chk("b_rst_s_tready", 64'(sb.tready), 64'd1);
    chk("b_rst_m_tvalid", 64'(mb.tvalid), 64'd0);

    // Four full 3-byte beats 0x00..0x0B -> three full 4-byte beats.
    pq.delete();
    for (int i = 0; i < 12; i++) pq.push_back(8'(i));
    send_pkt_a(pq, 8'h03, 1'b1);
    wait_drain("a_full_pkt_drain", 100);

    // Short tlast beat: 01..05 -> 0x04030201 then 0x05 keep 0001 tlast.
    pq.delete();
    for (int i = 1; i <= 5; i++) pq.push_back(8'(i));
    send_pkt_a(pq, 8'h04, 1'b0);
    wait_drain("a_short_pkt_drain", 100);

    // Zero-byte tlast with empty buffer, then after three buffered bytes.
    pq.delete();
    model_pkt(0, 4, pq, 8'h06, 1'b1);
    send_a(24'h0, 3'b000, 1'b1, 8'h06, 1'b1);
    wait_drain("a_zero_pkt_drain", 100);
    pq.delete();
    pq.push_back(8'h11); pq.push_back(8'h22); pq.push_back(8'h33);
    model_pkt(0, 4, pq, 8'h07, 1'b0);
    send_a(24'h332211, 3'b111, 1'b0, 8'h07, 1'b0);
    send_a(24'h0, 3'b000, 1'b1, 8'h07, 1'b0);
    wait_drain("a_zero_tail_drain", 100);

    // Back-to-back packets with distinct tid under output backpressure.
    rr_a = 1'b1;
    pq.delete();
    for (int i = 0; i < 7; i++) pq.push_back(8'($urandom));
    send_pkt_a(pq, 8'h05, 1'b0);
    pq.delete();
    for (int i = 0; i < 8; i++) pq.push_back(8'($urandom));
    send_pkt_a(pq, 8'h09, 1'b1);
    wait_drain("a_tid_pkts_drain", 300);
    rr_a = 1'b0;
    @(posedge clk); #1;

    // Mid-packet reset with two bytes left behind in the buffer.
    bt = '0; bt.dat = 64'h33221100; bt.keep = 8'h0F; bt.id = 8'h0A; bt.user = 1'b1;
    exp_a.push_back(bt);
    send_a(24'h221100, 3'b111, 1'b0, 8'h0A, 1'b1);
    send_a(24'h554433, 3'b111, 1'b0, 8'h0A, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    chk("a_pre_rst_beat_out", 64'(exp_a.size()), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_a.delete();
    chk("a_post_rst_m_tvalid", 64'(ma.tvalid), 64'd0);
    chk("a_post_rst_s_tready", 64'(sa.tready), 64'd1);
    pq.delete();
    for (int i = 0; i < 8; i++) pq.push_back(8'(8'hA0 + i));
    send_pkt_a(pq, 8'h01, 1'b0);
    wait_drain("a_post_rst_pkt_drain", 100);

    // 5->2 lanes: random packets against random output backpressure.
    rr_b = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      int nb, lastn;
      nb = $urandom_range(1, 4);
      lastn = $urandom_range(1, 5);
      pq.delete();
      for (int i = 0; i < 5 * (nb - 1) + lastn; i++) pq.push_back(8'($urandom));
      send_pkt_b(pq, 8'($urandom), 1'($urandom));
    end
    wait_drain("b_random_drain", 20000);
    rr_b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
